// File: rtl/timer_cmp_sched.sv
// -----------------------------------------------------------------------------
// timer_cmp_sched
//
// Multiplexes NumSlots software deadlines onto the single 64-bit mtimecmp of a
// memory-mapped timer. The block masters the timer's request/rvalid port. It
// always programs the earliest armed deadline, and it marks slots expired when
// the timer interrupt fires.
//
// Optional feature macro: TIMER_CMP_SCHED_READBACK_EN
//   When defined, each program sequence reads back cmp lo/hi after the writes.
//   A read value that differs from the programmed value sets err_o.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   cfg_valid_i/ready_o slot configuration handshake
//   cfg_slot_i          target slot index
//   cfg_arm_i           1 = arm with cfg_deadline_i, 0 = disarm
//   cfg_deadline_i      absolute 64-bit mtime deadline
//   armed_o             per-slot armed flags
//   expired_o           sticky per-slot expiry flags
//   expired_clr_i       per-bit clear of expired_o (a same-cycle set wins)
//   busy_o              scheduler not idle
//   err_o               sticky bus error / readback mismatch
//   timer_*             single-outstanding bus master port to the timer
//   timer_intr_i        timer interrupt level (mtime >= mtimecmp)
// -----------------------------------------------------------------------------
module timer_cmp_sched #(
    parameter int unsigned NumSlots     = 4,
    parameter int unsigned DataWidth    = 32,
    parameter int unsigned AddressWidth = 32,
    parameter logic [AddressWidth-1:0] TimerBase = {AddressWidth{1'b0}}
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        cfg_valid_i,
    output logic                        cfg_ready_o,
    input  logic [$clog2(NumSlots)-1:0] cfg_slot_i,
    input  logic                        cfg_arm_i,
    input  logic [63:0]                 cfg_deadline_i,
    output logic [NumSlots-1:0]         armed_o,
    output logic [NumSlots-1:0]         expired_o,
    input  logic [NumSlots-1:0]         expired_clr_i,
    output logic                        busy_o,
    output logic                        err_o,
    output logic                        timer_req_o,
    output logic [AddressWidth-1:0]     timer_addr_o,
    output logic                        timer_we_o,
    output logic [DataWidth/8-1:0]      timer_be_o,
    output logic [DataWidth-1:0]        timer_wdata_o,
    input  logic                        timer_rvalid_i,
    input  logic [DataWidth-1:0]        timer_rdata_i,
    input  logic                        timer_err_i,
    input  logic                        timer_intr_i
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SELECT  = 3'd1,
        WR_HMAX = 3'd2,
        WR_LO   = 3'd3,
        WR_HI   = 3'd4,
`ifdef TIMER_CMP_SCHED_READBACK_EN
        RD_LO   = 3'd5,
        RD_HI   = 3'd6,
`endif
        SETTLE  = 3'd7
    } state_e;

    localparam logic [AddressWidth-1:0] AddrCmpLo = TimerBase + AddressWidth'(32'd8);
    localparam logic [AddressWidth-1:0] AddrCmpHi = TimerBase + AddressWidth'(32'd12);
    localparam logic [63:0]             CmpPark   = {64{1'b1}};

    state_e                  state_q, state_d;
    logic [63:0]             deadline_q [NumSlots];
    logic [63:0]             deadline_d [NumSlots];
    logic [NumSlots-1:0]     armed_q, armed_d;
    logic [NumSlots-1:0]     expired_q, expired_d;
    logic                    err_q, err_d;
    logic [63:0]             cur_cmp_q, cur_cmp_d;
    logic                    req_q, req_d;
    logic [AddressWidth-1:0] addr_q, addr_d;
    logic                    we_q, we_d;
    logic [DataWidth-1:0]    wdata_q, wdata_d;

    logic [63:0]             min_cmp_s;
    logic [NumSlots-1:0]     due_s;
    logic [NumSlots-1:0]     slot_mask_s;
    logic                    cfg_ready_s;
    logic                    rsp_s;

`ifndef TIMER_CMP_SCHED_READBACK_EN
    // Read data is only consumed by the readback check.
    logic rdata_unused_s;
    assign rdata_unused_s = ^timer_rdata_i;
`endif

    assign cfg_ready_s = (state_q == IDLE) && !timer_intr_i;
    // A response can only belong to us once our request pulse has been sent;
    // this also drops a stale rvalid left over from a reset mid-transaction.
    assign rsp_s       = timer_rvalid_i && !req_q;
    // Out-of-range slot indices shift out and produce an empty mask.
    assign slot_mask_s = {{(NumSlots-1){1'b0}}, 1'b1} << cfg_slot_i;

    // Earliest armed deadline; strict less-than keeps the lowest index on a tie.
    always_comb begin
        min_cmp_s = CmpPark;
        for (int i = 0; i < NumSlots; i++) begin
            min_cmp_s = (armed_q[i] && (deadline_q[i] < min_cmp_s)) ? deadline_q[i] : min_cmp_s;
        end
    end

    // Slots whose deadline has been reached by the programmed compare value.
    always_comb begin
        for (int i = 0; i < NumSlots; i++) begin
            due_s[i] = armed_q[i] && (deadline_q[i] <= cur_cmp_q);
        end
    end

    // Next-state, slot bookkeeping and bus request generation.
    always_comb begin
        state_d    = state_q;
        deadline_d = deadline_q;
        armed_d    = armed_q;
        expired_d  = expired_q & ~expired_clr_i;
        err_d      = err_q;
        cur_cmp_d  = cur_cmp_q;
        req_d      = 1'b0;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;

        case (state_q)
            IDLE: begin
                if (timer_intr_i && (|armed_q)) begin
                    armed_d   = armed_q & ~due_s;
                    expired_d = expired_d | due_s;
                    state_d   = SELECT;
                end else if (cfg_valid_i && cfg_ready_s) begin
                    if (cfg_arm_i) begin
                        for (int i = 0; i < NumSlots; i++) begin
                            deadline_d[i] = slot_mask_s[i] ? cfg_deadline_i : deadline_q[i];
                        end
                        armed_d   = armed_q | slot_mask_s;
                        expired_d = expired_d & ~slot_mask_s;
                    end else begin
                        armed_d = armed_q & ~slot_mask_s;
                    end
                    // Always reprogram, even if the minimum is unchanged.
                    state_d = SELECT;
                end else begin
                    state_d = IDLE;
                end
            end

            SELECT: begin
                cur_cmp_d = min_cmp_s;
                state_d   = WR_HMAX;
                req_d     = 1'b1;
                addr_d    = AddrCmpHi;
                we_d      = 1'b1;
                wdata_d   = 32'hFFFF_FFFF;
            end

            // Parking cmp hi first means the lo write can never match early.
            WR_HMAX: begin
                if (rsp_s) begin
                    err_d   = err_q | timer_err_i;
                    state_d = WR_LO;
                    req_d   = 1'b1;
                    addr_d  = AddrCmpLo;
                    we_d    = 1'b1;
                    wdata_d = cur_cmp_q[31:0];
                end else begin
                    state_d = WR_HMAX;
                end
            end

            WR_LO: begin
                if (rsp_s) begin
                    err_d   = err_q | timer_err_i;
                    state_d = WR_HI;
                    req_d   = 1'b1;
                    addr_d  = AddrCmpHi;
                    we_d    = 1'b1;
                    wdata_d = cur_cmp_q[63:32];
                end else begin
                    state_d = WR_LO;
                end
            end

            WR_HI: begin
                if (rsp_s) begin
                    err_d = err_q | timer_err_i;
`ifdef TIMER_CMP_SCHED_READBACK_EN
                    state_d = RD_LO;
                    req_d   = 1'b1;
                    addr_d  = AddrCmpLo;
                    we_d    = 1'b0;
`else
                    state_d = SETTLE;
`endif
                end else begin
                    state_d = WR_HI;
                end
            end

`ifdef TIMER_CMP_SCHED_READBACK_EN
            RD_LO: begin
                if (rsp_s) begin
                    err_d   = err_q | timer_err_i | (timer_rdata_i != cur_cmp_q[31:0]);
                    state_d = RD_HI;
                    req_d   = 1'b1;
                    addr_d  = AddrCmpHi;
                    we_d    = 1'b0;
                end else begin
                    state_d = RD_LO;
                end
            end

            RD_HI: begin
                if (rsp_s) begin
                    err_d   = err_q | timer_err_i | (timer_rdata_i != cur_cmp_q[63:32]);
                    state_d = SETTLE;
                end else begin
                    state_d = RD_HI;
                end
            end
`endif

            // One cycle for the interrupt clear of the last write to show up.
            SETTLE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = SELECT;
            end
        endcase
    end

    // State and datapath registers; reset parks the compare via SELECT.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= SELECT;
            for (int i = 0; i < NumSlots; i++) begin
                deadline_q[i] <= 64'd0;
            end
            armed_q   <= {NumSlots{1'b0}};
            expired_q <= {NumSlots{1'b0}};
            err_q     <= 1'b0;
            cur_cmp_q <= CmpPark;
            req_q     <= 1'b0;
            addr_q    <= {AddressWidth{1'b0}};
            we_q      <= 1'b0;
            wdata_q   <= {DataWidth{1'b0}};
        end else begin
            state_q    <= state_d;
            deadline_q <= deadline_d;
            armed_q    <= armed_d;
            expired_q  <= expired_d;
            err_q      <= err_d;
            cur_cmp_q  <= cur_cmp_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
        end
    end

    assign cfg_ready_o   = cfg_ready_s;
    assign busy_o        = (state_q != IDLE);
    assign armed_o       = armed_q;
    assign expired_o     = expired_q;
    assign err_o         = err_q;
    assign timer_req_o   = req_q;
    assign timer_addr_o  = addr_q;
    assign timer_we_o    = we_q;
    assign timer_wdata_o = wdata_q;
    assign timer_be_o    = {(DataWidth/8){1'b1}};

endmodule

// File: tb/tb_timer_cmp_sched.sv
`timescale 1ns/1ps
module tb_timer_cmp_sched;

    localparam int          NS   = 4;
    localparam logic [31:0] BASE = 32'h0200_4000;
`ifdef TIMER_CMP_SCHED_READBACK_EN
    localparam int EXP_LAT = 12;
`else
    localparam int EXP_LAT = 8;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_i;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [1:0]    cfg_slot;
    logic          cfg_arm;
    logic [63:0]   cfg_dl;
    logic [NS-1:0] armed_o, expired_o, clr;
    logic          busy_o, err_o;
    logic          req, we;
    logic [31:0]   addr, wdata, rdata;
    logic [3:0]    be;
    logic          rvalid, terr, intr;

    timer_cmp_sched #(
        .NumSlots(NS), .DataWidth(32), .AddressWidth(32), .TimerBase(BASE)
    ) dut (
        .clk_i(clk), .rst_i(rst_i),
        .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready), .cfg_slot_i(cfg_slot),
        .cfg_arm_i(cfg_arm), .cfg_deadline_i(cfg_dl),
        .armed_o(armed_o), .expired_o(expired_o), .expired_clr_i(clr),
        .busy_o(busy_o), .err_o(err_o),
        .timer_req_o(req), .timer_addr_o(addr), .timer_we_o(we), .timer_be_o(be),
        .timer_wdata_o(wdata), .timer_rvalid_i(rvalid), .timer_rdata_i(rdata),
        .timer_err_i(terr), .timer_intr_i(intr)
    );

    // ---------------- timer model ----------------
    logic [63:0] mtime;
    logic [63:0] cmp;
    int          resp_delay = 0;
    bit          inj_err_lo = 1'b0;
    bit          inj_rd_hi  = 1'b0;
    logic        pend, pend_err, outst, req_prev;
    int          pend_cnt;
    logic [31:0] pend_data;
    logic [63:0] wlog[$];
    int          viol = 0;
    int          n_reads = 0;

    logic [31:0] m_off, m_rd;
    logic        m_err;
    assign intr  = (mtime >= cmp);
    assign m_off = addr - BASE;
    assign m_rd  = (m_off == 32'd8)  ? cmp[31:0] :
                   (m_off == 32'd12) ? (cmp[63:32] ^ {31'd0, inj_rd_hi}) :
                   (m_off == 32'd4)  ? mtime[63:32] : mtime[31:0];
    assign m_err = inj_err_lo && we && (m_off == 32'd8);

    always @(posedge clk) begin
        if (rst_i) begin
            cmp <= 64'd0; pend <= 1'b0; rvalid <= 1'b0; terr <= 1'b0;
            rdata <= 32'd0; outst <= 1'b0; req_prev <= 1'b0;
        end else begin
            rvalid   <= 1'b0;
            terr     <= 1'b0;
            req_prev <= req;
            if (rvalid) outst <= 1'b0;
            if (req) begin
                if (outst || req_prev) viol <= viol + 1;
                outst <= 1'b1;
                if (we) begin
                    wlog.push_back({addr, wdata});
                    if (m_off == 32'd8)       cmp[31:0]  <= wdata;
                    else if (m_off == 32'd12) cmp[63:32] <= wdata;
                    else                      viol <= viol + 1;
                end else begin
                    n_reads <= n_reads + 1;
                end
                if (resp_delay == 0) begin
                    rvalid <= 1'b1; terr <= m_err; rdata <= m_rd;
                end else begin
                    pend <= 1'b1; pend_cnt <= resp_delay - 1;
                    pend_err <= m_err; pend_data <= m_rd;
                end
            end else if (pend) begin
                if (pend_cnt == 0) begin
                    rvalid <= 1'b1; terr <= pend_err; rdata <= pend_data; pend <= 1'b0;
                end else begin
                    pend_cnt <= pend_cnt - 1;
                end
            end
        end
    end

    // ---------------- checking ----------------
    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // ---------------- reference model ----------------
    bit          m_armed [NS];
    bit          m_exp   [NS];
    logic [63:0] m_dl    [NS];

    function automatic logic [63:0] m_min();
        logic [63:0] r = {64{1'b1}};
        for (int i = 0; i < NS; i++) if (m_armed[i] && m_dl[i] < r) r = m_dl[i];
        return r;
    endfunction

    function automatic logic [NS-1:0] m_armed_vec();
        logic [NS-1:0] r;
        for (int i = 0; i < NS; i++) r[i] = m_armed[i];
        return r;
    endfunction

    function automatic logic [NS-1:0] m_exp_vec();
        logic [NS-1:0] r;
        for (int i = 0; i < NS; i++) r[i] = m_exp[i];
        return r;
    endfunction

    function automatic logic [63:0] wl(input int idx);
        if (idx < 0 || idx >= wlog.size()) return 64'd0;
        return wlog[idx];
    endfunction

    // Any armed deadline at or before mtime ends up expired and disarmed.
    task automatic m_settle();
        for (int i = 0; i < NS; i++)
            if (m_armed[i] && m_dl[i] <= mtime) begin m_exp[i] = 1'b1; m_armed[i] = 1'b0; end
    endtask

    task automatic m_clear();
        for (int i = 0; i < NS; i++) begin m_armed[i] = 1'b0; m_exp[i] = 1'b0; m_dl[i] = 64'd0; end
    endtask

    task automatic wait_ready();
        bit ok = 1'b0;
        for (int k = 0; k < 400 && !ok; k++) begin
            @(negedge clk);
            ok = cfg_ready;
        end
        if (!ok) check("ready_timeout", 64'd0, 64'd1);
    endtask

    task automatic do_cfg(input int slot, input bit arm, input logic [63:0] dl);
        wait_ready();
        cfg_valid = 1'b1; cfg_slot = 2'(slot); cfg_arm = arm; cfg_dl = dl;
        @(posedge clk);
        #1 cfg_valid = 1'b0;
        if (arm) begin m_dl[slot] = dl; m_armed[slot] = 1'b1; m_exp[slot] = 1'b0; end
        else m_armed[slot] = 1'b0;
    endtask

    task automatic wait_quiet();
        bit ok = 1'b0;
        for (int k = 0; k < 2000 && !ok; k++) begin
            @(negedge clk);
            ok = !busy_o && (!intr || armed_o == '0);
        end
        if (!ok) check("quiet_timeout", 64'd0, 64'd1);
    endtask

    task automatic check_state(input string tag);
        m_settle();
        check({tag, "_armed"},   64'(armed_o),   64'(m_armed_vec()));
        check({tag, "_expired"}, 64'(expired_o), 64'(m_exp_vec()));
        check({tag, "_cmp"},     cmp,            m_min());
    endtask

    task automatic pulse_clr(input logic [NS-1:0] v);
        @(negedge clk);
        clr = v;
        @(posedge clk);
        #1 clr = '0;
        for (int i = 0; i < NS; i++) if (v[i]) m_exp[i] = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        wlog.delete();
        rst_i = 1'b0;
        m_clear();
        wait_quiet();
    endtask

    initial begin
        int          lat;
        bit          seen;
        logic [63:0] dl;
        rst_i = 1'b1; cfg_valid = 1'b0; cfg_slot = '0; cfg_arm = 1'b0;
        cfg_dl = 64'd0; clr = '0; mtime = 64'd0;
        m_clear();
        repeat (3) @(negedge clk);
        check("rst_req",     64'(req),       64'd0);
        check("rst_busy",    64'(busy_o),    64'd1);
        check("rst_ready",   64'(cfg_ready), 64'd0);
        check("rst_armed",   64'(armed_o),   64'd0);
        check("rst_expired", 64'(expired_o), 64'd0);
        check("rst_err",     64'(err_o),     64'd0);
        wlog.delete();
        rst_i = 1'b0;
        wait_quiet();
        check("park_n",  64'(wlog.size()), 64'd3);
        check("park_w0", wl(0), {BASE + 32'd12, 32'hFFFF_FFFF});
        check("park_w1", wl(1), {BASE + 32'd8,  32'hFFFF_FFFF});
        check("park_w2", wl(2), {BASE + 32'd12, 32'hFFFF_FFFF});
        check("park_ready",   64'(cfg_ready), 64'd1);
        check("park_expired", 64'(expired_o), 64'd0);
        check("park_intr",    64'(intr),      64'd0);

        // Deadline already in the past when programmed.
        @(negedge clk);
        mtime = 64'h50;
        do_cfg(0, 1'b1, 64'h10);
        lat = 0; seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            @(negedge clk);
            if (busy_o) lat++; else seen = 1'b1;
        end
        check("past_latency", 64'(lat), 64'(EXP_LAT));
        check("past_intr",    64'(intr), 64'd1);
        check("past_exp_pre", 64'(expired_o[0]), 64'd0);
        @(negedge clk);
        check("past_exp_post", 64'(expired_o[0]), 64'd1);
        wait_quiet();
        check_state("past");
        pulse_clr(4'b0001);
        check_state("past_clr");

        // Earliest of two deadlines, including a 64-bit high word.
        @(negedge clk);
        mtime = 64'h100;
        do_cfg(2, 1'b1, 64'h0000_0001_0000_0100);
        do_cfg(0, 1'b1, 64'h200);
        wait_quiet();
        check("two_wlo", wl(wlog.size() - 2), {BASE + 32'd8,  32'h0000_0200});
        check("two_whi", wl(wlog.size() - 1), {BASE + 32'd12, 32'h0000_0000});
        check_state("two_arm");
        @(negedge clk);
        mtime = 64'h200;
        wait_quiet();
        check("two_exp_lit",   64'(expired_o), 64'h1);
        check("two_armed_lit", 64'(armed_o),   64'h4);
        check_state("two_hit");
        do_cfg(2, 1'b0, 64'd0);
        wait_quiet();
        check_state("two_disarm");

        // Tie between slots 1 and 3, expiring while their clear is held.
        pulse_clr(4'hF);
        @(negedge clk);
        mtime = 64'h400;
        do_cfg(1, 1'b1, 64'h500);
        do_cfg(3, 1'b1, 64'h500);
        wait_quiet();
        check_state("tie_arm");
        clr = 4'b1010;
        mtime = 64'h500;
        seen = 1'b0;
        for (int k = 0; k < 50 && !seen; k++) begin
            @(negedge clk);
            seen = (expired_o != '0);
        end
        check("tie_exp_set", 64'(expired_o), 64'hA);
        @(negedge clk);
        check("tie_exp_clr", 64'(expired_o), 64'h0);
        clr = '0;
        wait_quiet();
        m_settle();
        m_exp[1] = 1'b0; m_exp[3] = 1'b0;
        check_state("tie_done");

        // Randomized arm/disarm/time/clear traffic.
        mtime = 64'h800;
        for (int it = 0; it < 150; it++) begin
            int op;
            resp_delay = $urandom_range(0, 2);
            op = $urandom_range(0, 7);
            if (op <= 4) begin
                int s = $urandom_range(0, NS - 1);
                if ($urandom_range(0, 3) != 0) begin
                    dl = mtime + 64'($urandom_range(0, 32'h240)) - 64'h40;
                    if ($urandom_range(0, 3) == 0) dl = dl + 64'h1_0000_0000;
                    if ($urandom_range(0, 4) == 0) dl = m_dl[$urandom_range(0, NS - 1)];
                    do_cfg(s, 1'b1, dl);
                end else begin
                    do_cfg(s, 1'b0, 64'd0);
                end
            end else if (op <= 6) begin
                @(negedge clk);
                mtime = mtime + 64'($urandom_range(0, 32'h180));
                if ($urandom_range(0, 15) == 0) mtime = mtime + 64'h1_0000_0000;
            end else begin
                pulse_clr(4'($urandom_range(0, 15)));
            end
            wait_quiet();
            check_state($sformatf("rnd%0d", it));
        end
        check("rnd_err",  64'(err_o), 64'd0);
        check("bus_viol", 64'(viol),  64'd0);
        check("bus_be",   64'(be),    64'hF);
`ifdef TIMER_CMP_SCHED_READBACK_EN
        check("bus_reads", 64'(n_reads > 0), 64'd1);
`else
        check("bus_reads", 64'(n_reads), 64'd0);
`endif

        // Bus error on the cmp lo write: sticky, sequence still completes.
        resp_delay = 0;
        inj_err_lo = 1'b1;
        do_cfg(0, 1'b1, mtime + 64'h100);
        wait_quiet();
        inj_err_lo = 1'b0;
        check("err_set", 64'(err_o), 64'd1);
        check_state("err_seq");
        do_cfg(1, 1'b1, mtime + 64'h180);
        wait_quiet();
        check("err_sticky", 64'(err_o), 64'd1);
        do_reset();
        check("err_rst", 64'(err_o), 64'd0);
`ifdef TIMER_CMP_SCHED_READBACK_EN
        inj_rd_hi = 1'b1;
        do_cfg(2, 1'b1, mtime + 64'h100);
        wait_quiet();
        inj_rd_hi = 1'b0;
        check("rdbk_err", 64'(err_o), 64'd1);
        do_reset();
`endif

        // Reset while waiting for the cmp lo write response.
        resp_delay = 3;
        do_cfg(1, 1'b1, mtime + 64'h80);
        seen = 1'b0;
        for (int k = 0; k < 60 && !seen; k++) begin
            @(negedge clk);
            seen = req && (addr == BASE + 32'd8);
        end
        check("mid_seen_lo", 64'(seen), 64'd1);
        @(negedge clk);
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        check("mid_req",   64'(req),     64'd0);
        check("mid_armed", 64'(armed_o), 64'd0);
        @(negedge clk);
        wlog.delete();
        m_clear();
        rst_i = 1'b0;
        wait_quiet();
        check("mid_park_w0", wl(0), {BASE + 32'd12, 32'hFFFF_FFFF});
        check("mid_park_n",  64'(wlog.size()), 64'd3);
        check_state("mid_done");
        check("mid_viol", 64'(viol), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
